// File: rtl/pkt_queue_sf.sv
// Store-and-forward packet queue: beats are released downstream only once their packet's tlast is
// stored; aborted or overflowing packets are rolled back. Stats counters exist only with PKT_QUEUE_STATS_EN.
module pkt_queue_sf #(
  parameter int DATA_W = 256,
  parameter int MTY_W  = 32,
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [MTY_W-1:0]  s_axis_tuser_mty,
  output logic              s_axis_tready,
  input  logic              drop_incmpt_pkt,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [MTY_W-1:0]  m_axis_tuser_mty,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  stat_pkt_ok,
  output logic [CNT_W-1:0]  stat_pkt_drop
);
  localparam int W = DATA_W + 1 + MTY_W;
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;

  wstate_t         state_q;
  logic [ADDR_W:0] wr_q, commit_q, fp_q, rd_q;
  logic            rdy_q, inf_q, v0_q, v1_q;
  logic [W-1:0]    mem [0:(1<<ADDR_W)-1];
  logic [W-1:0]    rdata_q, sk0_q, sk1_q;
  logic            acc_s, full_s, wr_en_s, drop_ev_s, fetch_s, pop_s;
  logic [1:0]      occ_s;

  // rd_q advances only when a beat leaves m_axis, so words parked in the skid still count as used
  always_comb begin
    acc_s     = s_axis_tvalid && rdy_q;
    full_s    = ((wr_q - rd_q) == DEPTH);
    wr_en_s   = 1'b0;
    drop_ev_s = 1'b0;
    case (state_q)
      W_IDLE: begin
        wr_en_s   = acc_s && !(drop_incmpt_pkt || full_s);
        drop_ev_s = acc_s && (drop_incmpt_pkt || full_s);
      end
      W_PKT: begin
        wr_en_s   = acc_s && !(drop_incmpt_pkt || full_s);
        drop_ev_s = drop_incmpt_pkt || (acc_s && full_s);
      end
      default: begin
        wr_en_s   = 1'b0;
        drop_ev_s = 1'b0;
      end
    endcase
    pop_s   = v0_q && m_axis_tready;
    occ_s   = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, inf_q} - {1'b0, pop_s};
    fetch_s = (fp_q != commit_q) && (occ_s < 2'd2);
  end

  always_ff @(posedge aclk) begin
    if (wr_en_s) mem[wr_q[ADDR_W-1:0]] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser_mty};
    rdata_q <= mem[fp_q[ADDR_W-1:0]];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= W_IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      fp_q     <= '0;
      rd_q     <= '0;
      rdy_q    <= 1'b0;
      inf_q    <= 1'b0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      sk0_q    <= '0;
      sk1_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (drop_ev_s) begin
        wr_q    <= commit_q;
        state_q <= (acc_s && s_axis_tlast) ? W_IDLE : W_DROP;
      end else if (wr_en_s) begin
        wr_q <= wr_q + PTR_ONE;
        if (s_axis_tlast) begin
          commit_q <= wr_q + PTR_ONE;
          state_q  <= W_IDLE;
        end else begin
          state_q <= W_PKT;
        end
      end else if (state_q == W_DROP && acc_s && s_axis_tlast) begin
        state_q <= W_IDLE;
      end
      if (fetch_s) fp_q <= fp_q + PTR_ONE;
      if (pop_s) rd_q <= rd_q + PTR_ONE;
      inf_q <= fetch_s;
      // sk0 is the head presented on m_axis; sk1 catches the in-flight read word during a stall
      case ({inf_q, pop_s})
        2'b10: begin
          if (v0_q) begin
            sk1_q <= rdata_q;
            v1_q  <= 1'b1;
          end else begin
            sk0_q <= rdata_q;
            v0_q  <= 1'b1;
          end
        end
        2'b01: begin
          sk0_q <= sk1_q;
          v0_q  <= v1_q;
          v1_q  <= 1'b0;
        end
        2'b11: begin
          if (v1_q) begin
            sk0_q <= sk1_q;
            sk1_q <= rdata_q;
          end else begin
            sk0_q <= rdata_q;
          end
        end
        default: begin
          sk0_q <= sk0_q;
        end
      endcase
    end
  end

  assign s_axis_tready    = rdy_q;
  assign m_axis_tvalid    = v0_q;
  assign m_axis_tdata     = sk0_q[W-1 -: DATA_W];
  assign m_axis_tlast     = sk0_q[MTY_W];
  assign m_axis_tuser_mty = sk0_q[MTY_W-1:0];

`ifdef PKT_QUEUE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] ok_q, drop_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      if (wr_en_s && s_axis_tlast && ok_q != CNT_MAX) ok_q <= ok_q + CNT_ONE;
      if (drop_ev_s && drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
    end
  end

  assign stat_pkt_ok   = ok_q;
  assign stat_pkt_drop = drop_q;
`else
  assign stat_pkt_ok   = '0;
  assign stat_pkt_drop = '0;
`endif
endmodule

// File: tb/tb_pkt_queue_sf.sv
// Scoreboard bench for pkt_queue_sf (16-entry build); expected beats are queued as they are sent.
module tb_pkt_queue_sf;
  localparam int DATA_W = 32;
  localparam int MTY_W  = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W+MTY_W:0] word_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              s_axis_tvalid = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic [MTY_W-1:0]  s_axis_tuser_mty = '0;
  logic              s_axis_tready;
  logic              drop_incmpt_pkt = 1'b0;
  logic              m_axis_tvalid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic [MTY_W-1:0]  m_axis_tuser_mty;
  logic              m_axis_tready;
  logic [CNT_W-1:0]  stat_pkt_ok;
  logic [CNT_W-1:0]  stat_pkt_drop;

  word_t sb[$];
  word_t mon_w, prev_word, exp_w;
  int    vec_cnt = 0;
  int    err_cnt = 0;
  int    rx_cnt = 0;
  bit    mon_en = 1'b0;
  bit    prev_stall = 1'b0;
  int    rdy_mode = 0;
  int    exp_ok = 0;
  int    exp_drop = 0;

  always #5 aclk = ~aclk;

  pkt_queue_sf #(.DATA_W(DATA_W), .MTY_W(MTY_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser_mty(s_axis_tuser_mty), .s_axis_tready(s_axis_tready),
    .drop_incmpt_pkt(drop_incmpt_pkt),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser_mty(m_axis_tuser_mty), .m_axis_tready(m_axis_tready),
    .stat_pkt_ok(stat_pkt_ok), .stat_pkt_drop(stat_pkt_drop)
  );

  function automatic logic [CNT_W-1:0] stat_exp(input int v);
    logic [CNT_W-1:0] r;
    r = CNT_W'(v);
`ifndef PKT_QUEUE_STATS_EN
    r = '0;
`endif
    return r;
  endfunction

  // downstream ready pattern: 0 low, 1 high, 2 toggle, other random
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        2: m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // output monitor: payload hold while stalled, scoreboard compare on every transfer
  initial begin
    forever begin
      @(negedge aclk);
      if (!mon_en || areset) begin
        prev_stall = 1'b0;
      end else begin
        mon_w = {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty};
        if (prev_stall) begin
          vec_cnt++;
          if (m_axis_tvalid !== 1'b1 || mon_w !== prev_word) begin
            err_cnt++;
            $display("FAIL stall_hold: got valid=%0b word=%h, want valid=1 word=%h", m_axis_tvalid, mon_w, prev_word);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          vec_cnt++;
          rx_cnt++;
          if (sb.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_beat: got %h, want no beat", mon_w);
          end else begin
            exp_w = sb.pop_front();
            if (mon_w !== exp_w) begin
              err_cnt++;
              $display("FAIL beat_payload: got %h, want %h", mon_w, exp_w);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = mon_w;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge aclk); #1;
  endtask

  // n beats back to back; keep=1 queues them as expected output; drop pulsed on beat index drop_at
  task automatic send_pkt(input int n, input bit keep, input int drop_at);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid    = 1'b1;
      s_axis_tdata     = DATA_W'($urandom());
      s_axis_tlast     = (i == n - 1);
      s_axis_tuser_mty = MTY_W'($urandom());
      drop_incmpt_pkt  = (i == drop_at);
      if (keep) sb.push_back({s_axis_tdata, s_axis_tlast, s_axis_tuser_mty});
      step();
    end
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    drop_incmpt_pkt = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      step();
      t++;
    end
    vec_cnt++;
    if (sb.size() != 0) begin
      err_cnt++;
      $display("FAIL %s_drain: got %0d beats pending, want 0", tag, sb.size());
      sb.delete();
    end
    repeat (4) step();
    vec_cnt++;
    if (m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_idle: got tvalid=%0b, want 0", tag, m_axis_tvalid);
    end
  endtask

  task automatic check_stats(input string tag);
    vec_cnt += 2;
    if (stat_pkt_ok !== stat_exp(exp_ok)) begin
      err_cnt++;
      $display("FAIL %s_stat_ok: got %0d, want %0d", tag, stat_pkt_ok, stat_exp(exp_ok));
    end
    if (stat_pkt_drop !== stat_exp(exp_drop)) begin
      err_cnt++;
      $display("FAIL %s_stat_drop: got %0d, want %0d", tag, stat_pkt_drop, stat_exp(exp_drop));
    end
  endtask

  task automatic check_rx(input string tag, input int got, input int want);
    vec_cnt++;
    if (got != want) begin
      err_cnt++;
      $display("FAIL %s_count: got %0d beats, want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset;
    repeat (3) step();
    vec_cnt++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser_mty} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b data=%h last=%0b mty=%h, want all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser_mty);
    end
    exp_ok = 0;
    exp_drop = 0;
    check_stats("reset");
    areset = 1'b0;
    vec_cnt++;
    if (s_axis_tready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_rdy_low: got %0b, want 0", s_axis_tready);
    end
    step();
    vec_cnt++;
    if (s_axis_tready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_rdy_rise: got %0b, want 1", s_axis_tready);
    end
  endtask

  task automatic test_single;
    int r0;
    rdy_mode = 1;
    mon_en = 1'b1;
    step();
    r0 = rx_cnt;
    send_pkt(4, 1'b1, -1);
    vec_cnt++;
    if (m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_t1: got tvalid=%0b, want 0", m_axis_tvalid);
    end
    step();
    vec_cnt++;
    if (m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_t2: got tvalid=%0b, want 0", m_axis_tvalid);
    end
    step();
    vec_cnt++;
    if (m_axis_tvalid !== 1'b1) begin
      err_cnt++;
      $display("FAIL latency_t3: got tvalid=%0b, want 1", m_axis_tvalid);
    end
    wait_drain("single");
    check_rx("single", rx_cnt - r0, 4);
    exp_ok += 1;
    check_stats("single");
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rx_cnt;
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send_pkt(1, 1'b1, -1);
    wait_drain("b2b");
    check_rx("b2b", rx_cnt - r0, 3);
    exp_ok += 3;
    check_stats("b2b");
  endtask

  task automatic test_drop;
    int r0;
    r0 = rx_cnt;
    rdy_mode = 1;
    send_pkt(5, 1'b0, 1);
    send_pkt(2, 1'b1, -1);
    wait_drain("drop");
    check_rx("drop", rx_cnt - r0, 2);
    exp_ok += 1;
    exp_drop += 1;
    check_stats("drop");
  endtask

  task automatic test_full;
    int r0;
    rdy_mode = 0;
    repeat (2) step();
    r0 = rx_cnt;
    send_pkt(10, 1'b1, -1);
    send_pkt(8, 1'b0, -1);
    exp_ok += 1;
    exp_drop += 1;
    check_stats("full");
    vec_cnt++;
    if (m_axis_tvalid !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_head: got tvalid=%0b, want 1", m_axis_tvalid);
    end
    rdy_mode = 1;
    wait_drain("full");
    check_rx("full", rx_cnt - r0, 10);
  endtask

  task automatic test_wrap;
    int r0, total, n, t;
    r0 = rx_cnt;
    total = 0;
    rdy_mode = 3;
    for (int p = 0; p < 100; p++) begin
      n = $urandom_range(1, 8);
      t = 0;
      while (sb.size() + n > (1 << ADDR_W) && t < 300) begin
        step();
        t++;
      end
      if (sb.size() + n > (1 << ADDR_W)) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL wrap_space: got %0d beats pending, want <= %0d", sb.size(), (1 << ADDR_W) - n);
        break;
      end
      send_pkt(n, 1'b1, -1);
      total += n;
      exp_ok += 1;
    end
    rdy_mode = 1;
    wait_drain("wrap");
    check_rx("wrap", rx_cnt - r0, total);
    check_stats("wrap");
  endtask

  task automatic test_reset_midstream;
    int r0, t, stale;
    r0 = rx_cnt;
    rdy_mode = 1;
    send_pkt(8, 1'b1, -1);
    t = 0;
    while (rx_cnt - r0 < 2 && t < 50) begin
      step();
      t++;
    end
    check_rx("rst_pre", (rx_cnt - r0 >= 2) ? 2 : rx_cnt - r0, 2);
    mon_en = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    sb.delete();
    vec_cnt++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== '0) begin
      err_cnt++;
      $display("FAIL rst_mid_outputs: got vld=%0b rdy=%0b data=%h, want 0 0 0", m_axis_tvalid, s_axis_tready, m_axis_tdata);
    end
    step();
    vec_cnt++;
    if (s_axis_tready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_mid_rdy: got %0b, want 1", s_axis_tready);
    end
    stale = 0;
    repeat (20) begin
      if (m_axis_tvalid !== 1'b0) stale++;
      step();
    end
    check_rx("rst_stale", stale, 0);
    exp_ok = 0;
    exp_drop = 0;
    check_stats("rst_mid");
    mon_en = 1'b1;
    r0 = rx_cnt;
    send_pkt(3, 1'b1, -1);
    wait_drain("rst_post");
    check_rx("rst_post", rx_cnt - r0, 3);
    exp_ok = 1;
    check_stats("rst_post");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_full();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
